sram_1rw_param: RTL and testbench

SRAM_1RW_PARAM -- requirements
Module: sram_1rw_param

---
 rtl/sram_1rw_param.sv | 91 +++++++++
 tb/tb_sram_1rw_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_param.sv
// sram_1rw_param: single-port SRAM with byte-masked writes, power-up zero fill and 1/2-cycle read latency
// Build option SRAM_BYPASS_EN: a same-cycle read+write returns the post-write word
// (written bytes from I, masked bytes from the old contents); without it the read sees the pre-write word.
module sram_1rw_param #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024,
    parameter int RD_LAT = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             CE,
    input  logic             RSTB,
    input  logic             CSB,
    input  logic             WEB,
    input  logic             OEB,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] I,
    input  logic [NB-1:0]    BMB,
    output logic [WIDTH-1:0] O,
    output logic             OV,
    output logic             RDY
);
    typedef enum logic {INIT, READY} state_t;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam bit LAT2 = RD_LAT == 2;
    state_t state, state_nx;
    logic [AW-1:0] init_cnt, init_cnt_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic init_we, in_rng, rd_ok, wr_ok, p_v, out_v;
    logic [WIDTH-1:0] rd_word, p_d, out_d;

    assign in_rng = {1'b0, A} < DEPTH_W;
    assign rd_ok = RDY && !CSB && !OEB;
    assign wr_ok = RDY && !CSB && !WEB && in_rng;
    assign out_v = LAT2 ? p_v : rd_ok;
    assign out_d = LAT2 ? p_d : rd_word;

    // state, zero-fill counter and ready flag; RDY trails the READY state by one cycle
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            state <= INIT;
            init_cnt <= '0;
            RDY <= 1'b0;
        end else begin
            state <= state_nx;
            init_cnt <= init_cnt_nx;
            RDY <= state == READY;
        end
    end

    // zero-fill one address per cycle, leave INIT after the last word
    always_comb begin
        init_we = state == INIT;
        init_cnt_nx = init_we ? init_cnt + 1'b1 : init_cnt;
        state_nx = (init_we && init_cnt == LAST) ? READY : state;
    end

    // read word for the current address; out-of-range addresses read as zero
    always_comb begin
        rd_word = in_rng ? mem[A] : '0;
`ifdef SRAM_BYPASS_EN
        for (int b = 0; b < NB; b++)
            if (wr_ok && !BMB[b]) rd_word[8*b +: 8] = I[8*b +: 8];
`endif
    end

    // storage: zero fill during init, byte-masked user writes once ready
    always_ff @(posedge CE) begin
        if (init_we)
            mem[init_cnt] <= '0;
        else if (wr_ok)
            for (int b = 0; b < NB; b++)
                if (!BMB[b]) mem[A][8*b +: 8] <= I[8*b +: 8];
    end

    // read return path: middle stage used only for RD_LAT=2, O holds the last result
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            p_v <= 1'b0;
            p_d <= '0;
            OV <= 1'b0;
            O <= '0;
        end else begin
            p_v <= rd_ok;
            p_d <= rd_word;
            OV <= out_v;
            if (out_v) O <= out_d;
        end
    end
endmodule

// File: tb/tb_sram_1rw_param.sv
// tb_sram_1rw_param: two SRAM configurations checked against a per-instance behavioural model plus literal spot checks
module tb_sram_1rw_param;
    logic ce = 1'b0;
    always #5 ce = ~ce;
    logic rstb [2];
    logic csb [2];
    logic web [2];
    logic oeb [2];
    logic [11:0] a [2];
    logic [63:0] din [2];
    logic [7:0] bmb [2];
    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int DEP = g ? 1000 : 16;
        localparam int LAT = g ? 2 : 1;
        localparam int AWG = $clog2(DEP);
        logic [63:0] o;
        logic ov, rdy;
        sram_1rw_param #(.WIDTH(64), .DEPTH(DEP), .RD_LAT(LAT)) dut (
            .CE(ce), .RSTB(rstb[g]), .CSB(csb[g]), .WEB(web[g]), .OEB(oeb[g]),
            .A(a[g][AWG-1:0]), .I(din[g]), .BMB(bmb[g]), .O(o), .OV(ov), .RDY(rdy)
        );
        logic [63:0] mm [DEP];
        int due_q [$];
        logic [63:0] dat_q [$];
        logic [63:0] m_o = '0;
        logic [63:0] rd;
        logic m_ov = 1'b0;
        logic m_rdy = 1'b0;
        logic acc;
        int cyc = 0;
        int since = 0;
        int ai;
        // model: memory is zero after reset, usable DEP+1 edges later, reads return RD_LAT-1 edges after acceptance
        always @(posedge ce or negedge rstb[g]) begin
            if (!rstb[g]) begin
                foreach (mm[k]) mm[k] = '0;
                due_q.delete();
                dat_q.delete();
                m_o = '0;
                m_ov = 1'b0;
                m_rdy = 1'b0;
                since = 0;
            end else begin
                cyc++;
                since++;
                acc = m_rdy;
                ai = int'(a[g]);
                rd = '0;
`ifndef SRAM_BYPASS_EN
                if (ai < DEP) rd = mm[ai];
`endif
                if (acc && !csb[g] && !web[g] && ai < DEP)
                    for (int b = 0; b < 8; b++)
                        if (!bmb[g][b]) mm[ai][8*b +: 8] = din[g][8*b +: 8];
`ifdef SRAM_BYPASS_EN
                if (ai < DEP) rd = mm[ai];
`endif
                if (acc && !csb[g] && !oeb[g]) begin
                    due_q.push_back(cyc + LAT - 1);
                    dat_q.push_back(rd);
                end
                m_ov = 1'b0;
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    m_ov = 1'b1;
                    m_o = dat_q.pop_front();
                    void'(due_q.pop_front());
                end
                m_rdy = since > DEP;
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all();
        chk("u0.O", u[0].o, u[0].m_o);
        chk("u0.OV", 64'(u[0].ov), 64'(u[0].m_ov));
        chk("u0.RDY", 64'(u[0].rdy), 64'(u[0].m_rdy));
        chk("u1.O", u[1].o, u[1].m_o);
        chk("u1.OV", 64'(u[1].ov), 64'(u[1].m_ov));
        chk("u1.RDY", 64'(u[1].rdy), 64'(u[1].m_rdy));
    endtask

    task automatic tick();
        @(posedge ce);
        @(negedge ce);
        chk_all();
    endtask

    task automatic drive(int g, bit r, bit w, int addr, logic [63:0] d, logic [7:0] m);
        csb[g] = !(r || w);
        oeb[g] = !r;
        web[g] = !w;
        a[g] = 12'(addr);
        din[g] = d;
        bmb[g] = m;
    endtask

    task automatic nop(int g);
        drive(g, 1'b0, 1'b0, 0, '0, '1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            rstb[k] = 1'b0;
            nop(k);
        end
        tick();
        tick();
        chk("rst_O", u[0].o, 64'h0);
        chk("rst_OV", 64'(u[1].ov), 64'h0);
        chk("rst_RDY", 64'(u[0].rdy), 64'h0);
        rstb[0] = 1'b1;
        rstb[1] = 1'b1;
        n = 0;
        while (!u[0].rdy && n < 40) begin
            tick();
            n++;
        end
        chk("init_rdy_cycles", 64'(n), 64'd17);
        for (int k = 0; k < 16; k++) begin
            drive(0, 1'b1, 1'b0, k, '0, '1);
            tick();
            chk("init_zero_OV", 64'(u[0].ov), 64'h1);
            chk("init_zero_O", u[0].o, 64'h0);
        end
        nop(0);
        tick();
        chk("idle_OV", 64'(u[0].ov), 64'h0);
        drive(0, 1'b0, 1'b1, 5, 64'h1122334455667788, 8'h00);
        tick();
        drive(0, 1'b0, 1'b1, 5, 64'hAAAAAAAAAAAAAAAA, 8'hF0);
        tick();
        drive(0, 1'b1, 1'b0, 5, '0, '1);
        tick();
        chk("bytemask_O", u[0].o, 64'h11223344AAAAAAAA);
        drive(0, 1'b0, 1'b1, 5, 64'hDEADBEEFDEADBEEF, 8'hFF);
        tick();
        drive(0, 1'b1, 1'b0, 5, '0, '1);
        tick();
        chk("mask_all_O", u[0].o, 64'h11223344AAAAAAAA);
        drive(0, 1'b1, 1'b1, 7, '1, 8'h00);
        tick();
`ifdef SRAM_BYPASS_EN
        chk("collision_O", u[0].o, 64'hFFFFFFFFFFFFFFFF);
`else
        chk("collision_O", u[0].o, 64'h0);
`endif
        drive(0, 1'b1, 1'b0, 7, '0, '1);
        tick();
        chk("after_coll_O", u[0].o, 64'hFFFFFFFFFFFFFFFF);
        nop(0);
        n = 0;
        while (!u[1].rdy && n < 1100) begin
            tick();
            n++;
        end
        chk("u1_ready", 64'(u[1].rdy), 64'h1);
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1'b0, 1'b1, k, {16{4'(k)}}, 8'h00);
            tick();
        end
        nop(1);
        tick();
        drive(1, 1'b1, 1'b0, 1, '0, '1);
        tick();
        chk("lat_OV_first", 64'(u[1].ov), 64'h0);
        drive(1, 1'b1, 1'b0, 2, '0, '1);
        tick();
        chk("lat_OV_1", 64'(u[1].ov), 64'h1);
        chk("lat_O_1", u[1].o, 64'h1111111111111111);
        drive(1, 1'b1, 1'b0, 3, '0, '1);
        tick();
        chk("lat_OV_2", 64'(u[1].ov), 64'h1);
        chk("lat_O_2", u[1].o, 64'h2222222222222222);
        nop(1);
        tick();
        chk("lat_OV_3", 64'(u[1].ov), 64'h1);
        chk("lat_O_3", u[1].o, 64'h3333333333333333);
        tick();
        chk("lat_OV_end", 64'(u[1].ov), 64'h0);
        chk("lat_O_hold", u[1].o, 64'h3333333333333333);
        drive(1, 1'b0, 1'b1, 1010, '1, 8'h00);
        tick();
        drive(1, 1'b1, 1'b0, 1010, '0, '1);
        tick();
        nop(1);
        tick();
        chk("oor_OV", 64'(u[1].ov), 64'h1);
        chk("oor_O", u[1].o, 64'h0);
        drive(1, 1'b1, 1'b0, 10, '0, '1);
        tick();
        nop(1);
        tick();
        chk("oor_alias_O", u[1].o, 64'h0);
        drive(1, 1'b0, 1'b1, 4, 64'hCAFEF00D12345678, 8'h00);
        tick();
        drive(1, 1'b1, 1'b0, 4, '0, '1);
        tick();
        nop(1);
        tick();
        chk("pre_rst_O", u[1].o, 64'hCAFEF00D12345678);
        drive(1, 1'b1, 1'b0, 4, '0, '1);
        tick();
        nop(1);
        rstb[1] = 1'b0;
        #1;
        chk("midrst_O", u[1].o, 64'h0);
        chk("midrst_OV", 64'(u[1].ov), 64'h0);
        chk("midrst_RDY", 64'(u[1].rdy), 64'h0);
        tick();
        tick();
        rstb[1] = 1'b1;
        n = 0;
        while (!u[1].rdy && n < 1100) begin
            tick();
            n++;
        end
        chk("reinit_rdy_cycles", 64'(n), 64'd1001);
        drive(1, 1'b1, 1'b0, 4, '0, '1);
        tick();
        nop(1);
        tick();
        chk("reinit_OV", 64'(u[1].ov), 64'h1);
        chk("reinit_O", u[1].o, 64'h0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
